videogen_pattern_param: RTL and testbench

Parametrised successor to the fixed 720x480 test-pattern generator. It produces programmable raster timing with selectable sync polarity and four test patterns: LFSR noise, colour bars, grid and latency-tester box. Pattern mode changes are frame-synchronised, so a frame never tears. It also emits a frame-start strobe and a frame counter, and sits between the board clock and the video DAC/HDMI transmitter.

---
 rtl/videogen_pattern_param.sv | 123 ++++++++++++
 tb/tb_videogen_pattern_param.sv | 119 +++++++++++
 2 files changed

// File: rtl/videogen_pattern_param.sv
// videogen_pattern_param: programmable raster timing with noise/bars/grid/box test patterns.
// Optional VIDEOGEN_NOISE_SCROLL_EN: pixel LFSR free-runs across frames instead of reloading per frame.
module videogen_pattern_param #(
    parameter int          H_SYNCLEN    = 62,
    parameter int          H_BACKPORCH  = 60,
    parameter int          H_ACTIVE     = 720,
    parameter int          H_FRONTPORCH = 16,
    parameter int          V_SYNCLEN    = 6,
    parameter int          V_BACKPORCH  = 30,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FRONTPORCH = 9,
    parameter int          CNT_W        = 11,
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0,
    parameter logic [15:0] LFSR_SEED    = 16'h0001,
    parameter logic [7:0]  DENSITY      = 8'd2
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic        lt_active,
    output logic [7:0]  R_out,
    output logic [7:0]  G_out,
    output logic [7:0]  B_out,
    output logic        HSYNC_out,
    output logic        VSYNC_out,
    output logic        ENABLE_out,
    output logic        PCLK_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_SYNCLEN + H_BACKPORCH + H_ACTIVE + H_FRONTPORCH;
    localparam int V_TOTAL = V_SYNCLEN + V_BACKPORCH + V_ACTIVE + V_FRONTPORCH;
    localparam int BW      = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SL   = CNT_W'(H_SYNCLEN);
    localparam logic [CNT_W-1:0] V_SL   = CNT_W'(V_SYNCLEN);
    localparam logic [CNT_W-1:0] X_S    = CNT_W'(H_SYNCLEN + H_BACKPORCH);
    localparam logic [CNT_W-1:0] X_E    = CNT_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_S    = CNT_W'(V_SYNCLEN + V_BACKPORCH);
    localparam logic [CNT_W-1:0] Y_E    = CNT_W'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
    localparam logic [CNT_W-1:0] BX0    = CNT_W'(H_ACTIVE * 3 / 8);
    localparam logic [CNT_W-1:0] BX1    = CNT_W'(H_ACTIVE * 5 / 8);
    localparam logic [CNT_W-1:0] BY0    = CNT_W'(V_ACTIVE * 3 / 8);
    localparam logic [CNT_W-1:0] BY1    = CNT_W'(V_ACTIVE * 5 / 8);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x, y;
    logic [1:0]       mode_q, mode_d, eff;
    logic [15:0]      lfsr_q, lfsr_d, frame_cnt_q, frame_cnt_d;
    logic [23:0]      rgb_q, rgb_d;
    logic [2:0]       bar;
    logic             wrap_q, wrap_d, hs_q, hs_d, vs_q, vs_d, en_q, en_d, fs_q;
    logic             h_end, v_end, white, fb;

    always_comb begin
        h_end  = h_q == H_LAST;
        v_end  = v_q == V_LAST;
        h_d    = h_end ? '0 : h_q + 1'b1;
        v_d    = !h_end ? v_q : v_end ? '0 : v_q + 1'b1;
        wrap_d = h_end && v_end;
        mode_d = wrap_d ? mode : mode_q;
        hs_d   = h_q < H_SL ? HS_POL : ~HS_POL;
        vs_d   = v_q < V_SL ? VS_POL : ~VS_POL;
        en_d   = h_q >= X_S && h_q < X_E && v_q >= Y_S && v_q < Y_E;
        x      = h_q - X_S;
        y      = v_q - Y_S;
        eff    = lt_active ? 2'd3 : mode_q;
        bar    = '0;
        for (int k = 1; k < 8; k++) bar = bar + {2'b0, x >= CNT_W'(k * BW)};
        white  = eff == 2'd0 ? lfsr_q[7:0] < DENSITY :
                 eff == 2'd2 ? x[3:0] == 4'd0 || y[3:0] == 4'd0 :
                 x >= BX0 && x < BX1 && y >= BY0 && y < BY1;
        // bar index bits map straight onto colour gates: R off for 2,3,6,7; G off for 4..7; B off for odd
        rgb_d  = !en_d ? 24'h0 :
                 eff == 2'd1 ? {(bar[1] ? 8'h00 : 8'hC0), (bar[2] ? 8'h00 : 8'hC0), (bar[0] ? 8'h00 : 8'hC0)} :
                 {24{white}};
        fb     = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
`ifdef VIDEOGEN_NOISE_SCROLL_EN
        lfsr_d = en_d ? {lfsr_q[14:0], fb} : lfsr_q;
`else
        lfsr_d = wrap_q ? SEED : en_d ? {lfsr_q[14:0], fb} : lfsr_q;
`endif
        frame_cnt_d = frame_cnt_q + 16'(wrap_q);
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            h_q         <= '0;
            v_q         <= '0;
            mode_q      <= '0;
            lfsr_q      <= SEED;
            frame_cnt_q <= '0;
            wrap_q      <= 1'b0;
            hs_q        <= HS_POL;
            vs_q        <= VS_POL;
            en_q        <= 1'b0;
            rgb_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
            wrap_q      <= wrap_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            en_q        <= en_d;
            rgb_q       <= rgb_d;
            fs_q        <= wrap_q;
        end
    end

    assign {R_out, G_out, B_out} = rgb_q;
    assign HSYNC_out   = hs_q;
    assign VSYNC_out   = vs_q;
    assign ENABLE_out  = en_q;
    assign PCLK_out    = clk27;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_videogen_pattern_param.sv
// tb_videogen_pattern_param: scoreboard bench on a shrunken raster (41x25) so several frames fit in a short run.
module tb_videogen_pattern_param;
    localparam int HSL = 4, HBP = 3, HA = 32, HFP = 2;
    localparam int VSL = 2, VBP = 2, VA = 20, VFP = 1;
    localparam int HT = HSL + HBP + HA + HFP, VT = VSL + VBP + VA + VFP;
    localparam int FRAME = HT * VT;
    localparam logic HSP = 1'b1, VSP = 1'b0;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [7:0] DEN = 8'd100;
    localparam logic [43:0] RST_VEC = {HSP, VSP, 42'h0};

    logic clk27 = 1'b0, reset_n = 1'b0, lt_active = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] R_out, G_out, B_out;
    logic HSYNC_out, VSYNC_out, ENABLE_out, PCLK_out, frame_start;
    logic [15:0] frame_cnt;
    int checks = 0, errors = 0;
    logic [43:0] sb[$];
    logic [23:0] bars[8] = '{24'hC0C0C0, 24'hC0C000, 24'h00C0C0, 24'h00C000,
                             24'hC000C0, 24'hC00000, 24'h0000C0, 24'h000000};

    videogen_pattern_param #(
        .H_SYNCLEN(HSL), .H_BACKPORCH(HBP), .H_ACTIVE(HA), .H_FRONTPORCH(HFP),
        .V_SYNCLEN(VSL), .V_BACKPORCH(VBP), .V_ACTIVE(VA), .V_FRONTPORCH(VFP),
        .CNT_W(11), .HS_POL(HSP), .VS_POL(VSP), .LFSR_SEED(SEED), .DENSITY(DEN)
    ) dut (
        .clk27(clk27), .reset_n(reset_n), .mode(mode), .lt_active(lt_active),
        .R_out(R_out), .G_out(G_out), .B_out(B_out), .HSYNC_out(HSYNC_out),
        .VSYNC_out(VSYNC_out), .ENABLE_out(ENABLE_out), .PCLK_out(PCLK_out),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk27 = ~clk27;

    function automatic logic [43:0] dut_vec();
        return {HSYNC_out, VSYNC_out, ENABLE_out, frame_start, R_out, G_out, B_out, frame_cnt};
    endfunction

    task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference raster: expected outputs for the pixel seen at each edge go into the scoreboard
    initial begin
        int mh, mv, x, y;
        logic [1:0] mm, em;
        logic [15:0] ml, mfc;
        logic mwrap, hs, vs, en, last;
        logic [23:0] rgb;
        forever begin
            @(posedge clk27);
            if (!reset_n) begin
                mh = 0; mv = 0; mm = 0; ml = SEED; mfc = 0; mwrap = 0;
                sb.delete();
            end else begin
                hs = mh < HSL ? HSP : ~HSP;
                vs = mv < VSL ? VSP : ~VSP;
                x = mh - (HSL + HBP);
                y = mv - (VSL + VBP);
                en = x >= 0 && x < HA && y >= 0 && y < VA;
                em = lt_active ? 2'd3 : mm;
                if (!en) rgb = 24'h0;
                else if (em == 2'd0) rgb = ml[7:0] < DEN ? 24'hFFFFFF : 24'h0;
                else if (em == 2'd1) rgb = bars[x / (HA / 8)];
                else if (em == 2'd2) rgb = (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h0;
                else rgb = (x >= HA * 3 / 8 && x < HA * 5 / 8 && y >= VA * 3 / 8 && y < VA * 5 / 8) ? 24'hFFFFFF : 24'h0;
                if (mwrap) mfc = mfc + 16'd1;
                sb.push_back({hs, vs, en, mwrap, rgb, mfc});
                if (en) ml = {ml[14:0], ml[15] ^ ml[14] ^ ml[12] ^ ml[3]};
`ifndef VIDEOGEN_NOISE_SCROLL_EN
                if (mwrap) ml = SEED;
`endif
                last = mh == HT - 1 && mv == VT - 1;
                if (last) mm = mode;
                mwrap = last;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = mv == VT - 1 ? 0 : mv + 1;
                end else mh = mh + 1;
            end
        end
    end

    always @(negedge clk27) begin
        if (!reset_n) check("rst", dut_vec(), RST_VEC);
        else if (sb.size() > 0) check("px", dut_vec(), sb.pop_front());
    end

    initial begin
        repeat (3) @(negedge clk27);
        #2 reset_n = 1'b1;
        repeat (2 * FRAME + 50) @(negedge clk27);
        mode = 2'd1;
        repeat (FRAME + FRAME / 2) @(negedge clk27);
        mode = 2'd2;
        repeat (FRAME) @(negedge clk27);
        mode = 2'd0;
        repeat (FRAME + 10 * HT + 15) @(negedge clk27);
        lt_active = 1'b1;
        repeat (6 * HT) @(negedge clk27);
        lt_active = 1'b0;
        repeat (FRAME / 3) @(negedge clk27);
        #2 reset_n = 1'b0;
        #1 check("arst", dut_vec(), RST_VEC);
        repeat (3) @(negedge clk27);
        #2 reset_n = 1'b1;
        repeat (FRAME + 100) @(negedge clk27);
        if (checks < 12) begin
            errors++;
            $display("FAIL count got %0d expected at least 12", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
